instruction_loader: RTL

INSTRUCTION_LOADER -- requirements
Module: instruction_loader

---
 rtl/instruction_loader.sv | 123 ++++++++++++
 1 files changed

// File: rtl/instruction_loader.sv
// Instruction loader: assembles big-endian words from a byte stream and
// writes them to instruction memory at consecutive word addresses until the
// halt word arrives or the memory is full.
//
// state   | meaning
// --------+-------------------------------------------------------------
// IDLE    | waiting for the first i_start after reset
// RECEIVE | collecting up to four bytes of the current word
// WRITE   | one-cycle memory write of the assembled word
// DONE    | load finished (o_error tells halt vs. memory full)
module instruction_loader #(
  parameter int                        NB_PC          = 32,
  parameter int                        NB_INSTRUCTION = 32,
  parameter int                        NB_BYTE        = 8,
  parameter int                        MEM_DEPTH      = 256,
  parameter logic [NB_INSTRUCTION-1:0] HALT_WORD      = 32'hFFFF_FFFF
) (
  input  logic                      i_clock,
  input  logic                      i_reset,
  input  logic                      i_start,
  input  logic [NB_BYTE-1:0]        i_rx_data,
  input  logic                      i_rx_valid,
  output logic                      o_wr_enable,
  output logic [NB_PC-1:0]          o_wr_addr,
  output logic [NB_INSTRUCTION-1:0] o_wr_data,
  output logic                      o_busy,
  output logic                      o_done,
  output logic                      o_error
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECEIVE = 2'd1,
    ST_WRITE   = 2'd2,
    ST_DONE    = 2'd3
  } state_t;

  // Byte address of the last word slot; reaching it without a halt is an overflow.
  localparam logic [NB_PC-1:0] LAST_ADDR = NB_PC'((MEM_DEPTH - 1) * 4);

  state_t                      state_q;
  logic [NB_PC-1:0]            addr_q;
  logic [NB_PC-1:0]            addr_d;
  logic [NB_INSTRUCTION-1:0]   word_q;
  logic [NB_INSTRUCTION-1:0]   word_d;
  logic [1:0]                  cnt_q;
  logic [1:0]                  cnt_d;
  logic                        done_q;
  logic                        error_q;

  // Candidate next values: word with the incoming byte shifted in low, next slot, next byte index.
  always_comb begin
    word_d = {word_q[NB_INSTRUCTION-NB_BYTE-1:0], i_rx_data};
    addr_d = addr_q + NB_PC'(4);
    cnt_d  = cnt_q + 2'd1;
  end

  // Load sequencer: byte assembly, write pulse, and termination decision.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      word_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      error_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE, ST_DONE: begin
          if (i_start) begin
            state_q <= ST_RECEIVE;
            addr_q  <= '0;
            word_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
          end
        end
        ST_RECEIVE: begin
          if (i_rx_valid) begin
            word_q <= word_d;
            cnt_q  <= cnt_d;
            if (cnt_q == 2'd3) begin
              state_q <= ST_WRITE;
            end
          end
        end
        ST_WRITE: begin
          if (word_q == HALT_WORD) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            error_q <= 1'b0;
            cnt_q   <= '0;
          end else if (addr_q == LAST_ADDR) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
            error_q <= 1'b1;
            cnt_q   <= '0;
          end else begin
            state_q <= ST_RECEIVE;
            addr_q  <= addr_d;
            // A byte arriving during the write is the first byte of the next word.
            if (i_rx_valid) begin
              word_q <= word_d;
              cnt_q  <= 2'd1;
            end
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign o_wr_enable = (state_q == ST_WRITE);
  assign o_busy      = (state_q == ST_RECEIVE) || (state_q == ST_WRITE);
  assign o_wr_addr   = addr_q;
  assign o_wr_data   = word_q;
  assign o_done      = done_q;
  assign o_error     = error_q;

endmodule
